uart_transmitter: RTL and testbench



---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_transmitter_if.sv | 12 +
 rtl/uart_baud_gen.sv | 42 ++++
 rtl/uart_transmitter.sv | 125 ++++++++++++
 tb/tb_uart_transmitter.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants, types and helpers for the TX and RX paths.
package uart_pkg;

  localparam int unsigned CLK_FREQ_DEF  = 100_000_000;
  localparam int unsigned BAUD_RATE_DEF = 9_600;
  localparam int unsigned DIV_DEF       = CLK_FREQ_DEF / BAUD_RATE_DEF;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned NBITS  = 10;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [NBITS-1:0]  frame_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1
  } tx_state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_transmitter_if.sv
// Byte handoff between the command sequencer and the UART transmitter.
interface uart_transmitter_if;
  import uart_pkg::*;

  logic  tx_valid;
  data_t tx_data;
  logic  tx_ready;

  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_data, output tx_ready);

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer: tick pulses for one cycle every DIV cycles after clear drops.
module uart_baud_gen #(
  parameter int unsigned DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);
  import uart_pkg::*;

  localparam int unsigned CNT_W = cnt_width(DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Count 0..DIV-1; tick is registered so it is high exactly while the count sits at DIV-1.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (clear || (cnt_q == CNT_W'(DIV - 1))) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    tick_d = (cnt_d == CNT_W'(DIV - 1));
  end

  // Counter and tick registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter: start bit, 8 data bits LSB first, stop bit, all outputs registered.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = CLK_FREQ_DEF,
  parameter int unsigned BAUD_RATE = BAUD_RATE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  uart_transmitter_if.slave host,
  output logic              TxD,
  output logic              busy,
  output logic              tx_done
);

  localparam int unsigned DIV   = CLK_FREQ / BAUD_RATE;
  localparam int unsigned BIT_W = cnt_width(NBITS);

  tx_state_e        state_q, state_d;
  frame_t           shreg_q, shreg_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic             txd_q, txd_d;
  logic             tx_ready_q, tx_ready_d;
  logic             busy_q, busy_d;
  logic             tx_done_q, tx_done_d;
  logic             baud_clear_c;
  logic             tick;

  // Bit timer is held cleared while idle so the first bit gets a full DIV cycles.
  uart_baud_gen #(
    .DIV (DIV)
  ) u_baud_gen (
    .clk   (clk),
    .rst   (rst),
    .clear (baud_clear_c),
    .tick  (tick)
  );

  // Next-state and next-output logic; TxD is computed one cycle early so the pin is a flop.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_d        = bit_q;
    txd_d        = txd_q;
    tx_ready_d   = tx_ready_q;
    busy_d       = busy_q;
    tx_done_d    = 1'b0;
    baud_clear_c = 1'b1;

    unique case (state_q)
      IDLE: begin
        txd_d      = 1'b1;
        tx_ready_d = 1'b1;
        busy_d     = 1'b0;
        if (host.tx_valid && tx_ready_q) begin
          shreg_d    = {STOP_BIT, host.tx_data, START_BIT};
          bit_d      = '0;
          state_d    = SEND;
          txd_d      = START_BIT;
          tx_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end

      SEND: begin
        baud_clear_c = 1'b0;
        txd_d        = shreg_q[0];
        tx_ready_d   = 1'b0;
        busy_d       = 1'b1;
        if (tick) begin
          if (bit_q == BIT_W'(NBITS - 1)) begin
            // Stop bit has run its full period: frame complete.
            state_d    = IDLE;
            shreg_d    = '1;
            bit_d      = '0;
            txd_d      = 1'b1;
            tx_ready_d = 1'b1;
            busy_d     = 1'b0;
            tx_done_d  = 1'b1;
          end else begin
            shreg_d = {STOP_BIT, shreg_q[NBITS-1:1]};
            bit_d   = bit_q + BIT_W'(1);
            txd_d   = shreg_q[1];
          end
        end
      end

      default: begin
        state_d    = IDLE;
        shreg_d    = '1;
        bit_d      = '0;
        txd_d      = 1'b1;
        tx_ready_d = 1'b1;
        busy_d     = 1'b0;
      end
    endcase
  end

  // State and output registers; reset forces the line high immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shreg_q    <= '1;
      bit_q      <= '0;
      txd_q      <= 1'b1;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_q      <= bit_d;
      txd_q      <= txd_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
      tx_done_q  <= tx_done_d;
    end
  end

  assign host.tx_ready = tx_ready_q;
  assign TxD           = txd_q;
  assign busy          = busy_q;
  assign tx_done       = tx_done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter with a frame-level reference model and per-cycle compare.
module tb_uart_transmitter;

  localparam int unsigned CLK_FREQ = 1_600_000;
  localparam int unsigned BAUD     = 100_000;
  localparam int unsigned DIV      = 16;
  localparam int unsigned FRAME    = 10 * DIV;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic TxD, busy, tx_done;

  uart_transmitter_if ifc();

  uart_transmitter #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .host    (ifc.slave),
    .TxD     (TxD),
    .busy    (busy),
    .tx_done (tx_done)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: a frame is just a byte plus the cycle offset since its handshake.
  logic        m_active = 1'b0;
  logic        m_done   = 1'b0;
  int unsigned m_off    = 0;
  logic [7:0]  m_byte   = 8'h00;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 1'b0;
      m_done   <= 1'b0;
      m_off    <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_active) begin
        if (m_off == FRAME - 1) begin
          m_active <= 1'b0;
          m_done   <= 1'b1;
        end else begin
          m_off <= m_off + 1;
        end
      end else if (ifc.tx_valid) begin
        m_active <= 1'b1;
        m_off    <= 0;
        m_byte   <= ifc.tx_data;
      end
    end
  end

  // Line level of bit slot idx of an 8N1 frame carrying b.
  function automatic logic frame_bit(input logic [7:0] b, input int unsigned idx);
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return b[idx-1];
  endfunction

  int n_vec = 0;
  int n_err = 0;
  int unsigned hs_cnt = 0;
  int unsigned done_cnt = 0;
  int unsigned hs_q[$];
  int unsigned done_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare of {TxD, tx_ready, busy, tx_done} against the model, plus event logging.
  task automatic monitor();
    logic [3:0] exp;
    forever begin
      @(negedge clk);
      exp = {m_active ? frame_bit(m_byte, m_off / DIV) : 1'b1, !m_active, m_active, m_done};
      check("cycle_outputs", {28'd0, TxD, ifc.tx_ready, busy, tx_done}, {28'd0, exp});
      if (!rst && ifc.tx_valid && ifc.tx_ready) begin
        hs_cnt++;
        hs_q.push_back(cyc + 1);
      end
      if (tx_done) begin
        done_cnt++;
        done_q.push_back(cyc);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // One-cycle valid pulse; t is the handshake edge.
  task automatic pulse(input logic [7:0] b, output int unsigned t);
    step();
    ifc.tx_valid = 1'b1;
    ifc.tx_data  = b;
    t = cyc + 1;
    step();
    ifc.tx_valid = 1'b0;
  endtask

  // Simple receiver: find the start bit, then sample each bit near its middle.
  task automatic capture(input string name, output logic [9:0] seq);
    int unsigned k;
    seq = '1;
    k = 0;
    while (TxD !== 1'b0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    check({name, "_start_seen"}, {31'd0, TxD}, 32'd0);
    if (TxD === 1'b0) begin
      repeat (7) @(negedge clk);
      seq[0] = TxD;
      for (int i = 1; i < 10; i++) begin
        repeat (DIV) @(negedge clk);
        seq[i] = TxD;
      end
    end
  endtask

  task automatic wait_done(input string name, output int unsigned d);
    int unsigned k;
    k = 0;
    d = 0;
    while (k < 400) begin
      @(negedge clk);
      k++;
      if (tx_done === 1'b1) break;
    end
    check({name, "_done_seen"}, {31'd0, tx_done}, 32'd1);
    d = cyc;
  endtask

  logic [9:0]  s1, s2;
  int unsigned t, d, h0, d0, lows, hs2, dn1;
  logic [7:0]  lb [4] = '{8'h00, 8'h5A, 8'hC3, 8'hFF};

  initial begin
    ifc.tx_valid = 1'b0;
    ifc.tx_data  = 8'h00;
    fork
      monitor();
    join_none

    // Power-on reset
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    check("reset_txd",   {31'd0, TxD},          32'd1);
    check("reset_ready", {31'd0, ifc.tx_ready}, 32'd1);
    check("reset_busy",  {31'd0, busy},         32'd0);
    check("reset_done",  {31'd0, tx_done},      32'd0);
    repeat (5) step();

    // Single byte 0x55
    pulse(8'h55, t);
    fork
      capture("b55", s1);
      wait_done("b55", d);
    join
    check("b55_bits",    {22'd0, s1}, 32'h2AA);
    check("b55_latency", d - t,       32'd160);
    check("b55_ready",   {31'd0, ifc.tx_ready}, 32'd1);
    repeat (4) step();

    // Extremes
    pulse(8'h00, t);
    lows = 0;
    repeat (200) begin
      @(negedge clk);
      if (TxD === 1'b0) lows++;
    end
    check("b00_low_cycles", lows, 32'd144);
    pulse(8'hFF, t);
    lows = 0;
    repeat (200) begin
      @(negedge clk);
      if (TxD === 1'b0) lows++;
    end
    check("bFF_low_cycles", lows, 32'd16);

    // Back-to-back with valid held
    h0 = hs_cnt;
    step();
    ifc.tx_valid = 1'b1;
    ifc.tx_data  = 8'hA5;
    step();
    ifc.tx_data  = 8'h3C;
    capture("bA5", s1);
    capture("b3C", s2);
    step();
    ifc.tx_valid = 1'b0;
    repeat (20) step();
    check("b2b_bits_first",  {22'd0, s1}, 32'h34A);
    check("b2b_bits_second", {22'd0, s2}, 32'h278);
    check("b2b_handshakes",  hs_cnt - h0, 32'd2);
    if (hs_q.size() >= 2 && done_q.size() >= 2) begin
      hs2 = hs_q[hs_q.size()-1];
      dn1 = done_q[done_q.size()-2];
      check("b2b_period",   hs2 - hs_q[hs_q.size()-2], 32'd161);
      check("b2b_idle_gap", hs2 - dn1,                 32'd1);
    end

    // Input churn during a 0x81 frame
    h0 = hs_cnt;
    pulse(8'h81, t);
    fork
      capture("b81", s1);
      wait_done("b81", d);
      begin
        for (int i = 0; i < 40; i++) begin
          ifc.tx_data  = 8'h7E;
          ifc.tx_valid = i[0];
          step();
        end
        ifc.tx_valid = 1'b0;
      end
    join
    check("b81_bits",       {22'd0, s1}, 32'h302);
    check("b81_handshakes", hs_cnt - h0, 32'd1);
    check("b81_latency",    d - t,       32'd160);

    // Reset 70 cycles into a frame
    pulse(8'h81, t);
    repeat (70) step();
    #1 rst = 1'b1;
    #1;
    check("midrst_txd",   {31'd0, TxD},          32'd1);
    check("midrst_busy",  {31'd0, busy},         32'd0);
    check("midrst_ready", {31'd0, ifc.tx_ready}, 32'd1);
    check("midrst_done",  {31'd0, tx_done},      32'd0);
    d0 = done_cnt;
    step();
    step();
    rst = 1'b0;
    ifc.tx_valid = 1'b1;
    ifc.tx_data  = 8'h42;
    t = cyc + 1;
    step();
    ifc.tx_valid = 1'b0;
    if (hs_q.size() >= 1) check("b42_first_edge", hs_q[hs_q.size()-1], t);
    capture("b42", s1);
    check("midrst_no_done", done_cnt - d0, 32'd0);
    wait_done("b42", d);
    check("b42_bits",    {22'd0, s1}, 32'h284);
    check("b42_latency", d - t,       32'd160);

    // Loopback through the bench receiver
    for (int i = 0; i < 4; i++) begin
      pulse(lb[i], t);
      fork
        capture("loop", s1);
        wait_done("loop", d);
      join
      check("loop_rx_data", {24'd0, s1[8:1]}, {24'd0, lb[i]});
      check("loop_framing", {30'd0, s1[9], s1[0]}, 32'd2);
    end

    repeat (5) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
